// File: rtl/debounce_sync.sv
// Input conditioning: synchronizes an asynchronous raw level into clk and
// debounces it, producing a registered level, its complement and edge pulses.
module debounce_sync #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 d_in,
  input  logic                                 en,
  output logic                                 q,
  output logic                                 qb,
  output logic                                 rise,
  output logic                                 fall,
  output logic                                 busy,
  output logic                                 o_dbg_state,
  output logic [$clog2(DEBOUNCE_CYCLES+1)-1:0] o_dbg_cnt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_CONFIRM = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_q;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_busy;

  // d_in is only ever observed through the last synchronizer flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d_in};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // r_cnt holds the number of enabled disagreement cycles seen so far in the run;
  // the flip happens on the enabled cycle that would make it DEBOUNCE_CYCLES.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_STABLE;
      r_q     <= RESET_VAL;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        ST_STABLE: begin
          if (w_s != r_q) begin
            if (en && (DEBOUNCE_CYCLES == 1)) begin
              r_q    <= w_s;
              r_rise <= w_s;
              r_fall <= ~w_s;
              r_cnt  <= '0;
            end else begin
              r_state <= ST_CONFIRM;
              r_busy  <= 1'b1;
              r_cnt   <= en ? CNT_ONE : '0;
            end
          end
        end
        ST_CONFIRM: begin
          if (w_s == r_q) begin
            r_state <= ST_STABLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (en && (r_cnt == CNT_LAST)) begin
            r_q     <= w_s;
            r_rise  <= w_s;
            r_fall  <= ~w_s;
            r_cnt   <= '0;
            r_state <= ST_STABLE;
            r_busy  <= 1'b0;
          end else if (en) begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_STABLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign q           = r_q;
  assign qb          = ~r_q;
  assign rise        = r_rise;
  assign fall        = r_fall;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;
  assign o_dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: a default instance and a DEBOUNCE_CYCLES=1 instance
// share stimulus; a per-cycle reference model feeds expected-output queues.
module tb_debounce_sync;

  localparam int SYNC = 2;
  localparam int DA   = 16;
  localparam int DB   = 1;

  // Handshake-free design: inputs change on the falling edge, outputs are
  // sampled 1 time unit after the rising edge that produced them.
  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic d_in  = 1'b0;
  logic en    = 1'b0;

  logic       q_a, qb_a, rise_a, fall_a, busy_a, st_a;
  logic [4:0] cnt_a;
  logic       q_b, qb_b, rise_b, fall_b, busy_b, st_b;
  logic [0:0] cnt_b;

  debounce_sync #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DA), .RESET_VAL(1'b0)) u_dut_a (
    .clk(clk), .reset(reset), .d_in(d_in), .en(en),
    .q(q_a), .qb(qb_a), .rise(rise_a), .fall(fall_a), .busy(busy_a),
    .o_dbg_state(st_a), .o_dbg_cnt(cnt_a)
  );

  debounce_sync #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB), .RESET_VAL(1'b0)) u_dut_b (
    .clk(clk), .reset(reset), .d_in(d_in), .en(en),
    .q(q_b), .qb(qb_b), .rise(rise_b), .fall(fall_b), .busy(busy_b),
    .o_dbg_state(st_b), .o_dbg_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_a_q[$];
  logic [4:0] exp_b_q[$];

  logic m_hist[SYNC];
  logic m_q[2];
  int   m_run[2];

  int n_edge      = 0;
  int rise_edge_a = -1;
  int busy_edge_a = -1;
  int rise_edge_b = -1;
  int rise_cnt_a  = 0;
  int rise_cnt_b  = 0;
  int fall_cnt_b  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (edge %0d)", tag, obs, exp, n_edge);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < SYNC; j++) m_hist[j] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_q[i]   = 1'b0;
      m_run[i] = 0;
    end
    exp_a_q.delete();
    exp_b_q.delete();
  endtask

  // One clock cycle: drive, predict, let the edge happen, compare.
  task automatic cycle(input logic din, input logic e);
    logic       s;
    logic       flip;
    logic       mb;
    int         d;
    logic [4:0] exp_v;
    @(negedge clk);
    d_in = din;
    en   = e;
    s = m_hist[SYNC-1];
    for (int i = 0; i < 2; i++) begin
      d    = (i == 0) ? DA : DB;
      flip = 1'b0;
      mb   = 1'b0;
      if (s != m_q[i]) begin
        if (e) m_run[i]++;
        if (m_run[i] == d) begin
          flip     = 1'b1;
          m_run[i] = 0;
          m_q[i]   = s;
        end else begin
          mb = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
      exp_v = {m_q[i], ~m_q[i], flip & m_q[i], flip & ~m_q[i], mb};
      if (i == 0) exp_a_q.push_back(exp_v);
      else        exp_b_q.push_back(exp_v);
    end
    for (int j = SYNC - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = din;
    @(posedge clk);
    n_edge++;
    #1;
    check("a_out", {27'd0, q_a, qb_a, rise_a, fall_a, busy_a}, {27'd0, exp_a_q.pop_front()});
    check("b_out", {27'd0, q_b, qb_b, rise_b, fall_b, busy_b}, {27'd0, exp_b_q.pop_front()});
    check("a_cnt_bound", {31'd0, (cnt_a <= 5'(DA - 1))}, 32'd1);
    if (rise_a) rise_cnt_a++;
    if (rise_b) rise_cnt_b++;
    if (fall_b) fall_cnt_b++;
    if (rise_a && rise_edge_a < 0) rise_edge_a = n_edge;
    if (busy_a && busy_edge_a < 0) busy_edge_a = n_edge;
    if (rise_b && rise_edge_b < 0) rise_edge_b = n_edge;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_a"}, {25'd0, q_a, qb_a, rise_a, fall_a, busy_a, st_a, cnt_a},
          {25'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0});
    check({tag, "_b"}, {27'd0, q_b, qb_b, rise_b, fall_b, busy_b},
          {27'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
  endtask

  initial begin
    int k;
    int len;
    logic v;

    // Asynchronous reset with d_in=1, before any rising clock edge.
    d_in = 1'b1;
    #1 reset = 1'b0;
    #1 check_reset_state("rst_async");
    d_in = 1'b0;
    model_reset();
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);

    // Clean rise with en held high: busy two edges in, q at k+17.
    rise_edge_a = -1; busy_edge_a = -1; rise_cnt_a = 0;
    k = n_edge + 1;
    for (int i = 0; i < 25; i++) cycle(1'b1, 1'b1);
    check("t2_busy_edge", busy_edge_a, k + 2);
    check("t2_rise_edge", rise_edge_a, k + SYNC + DA - 1);
    check("t2_rise_count", rise_cnt_a, 1);

    // Return to low, then a 10-cycle glitch that must be rejected.
    for (int i = 0; i < 25; i++) cycle(1'b0, 1'b1);
    check("t3_q_low", {31'd0, q_a}, 32'd0);
    rise_cnt_a = 0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1);
    check("t3_no_rise", rise_cnt_a, 0);

    // Sparse strobe: 16 enabled cycles at one-in-four spacing.
    rise_edge_a = -1;
    k = n_edge + 1;
    for (int i = 0; i < 80; i++) cycle(1'b1, (i % 4) == 0);
    check("t4_rise_edge", rise_edge_a, k + 64);

    // Reset asserted mid-confirm discards the partial count.
    for (int i = 0; i < 25; i++) cycle(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1);
    check("t5_busy_before", {31'd0, busy_a}, 32'd1);
    reset = 1'b0;
    #1 check_reset_state("t5_rst");
    model_reset();
    #1 reset = 1'b1;
    rise_edge_a = -1;
    k = n_edge + 1;
    for (int i = 0; i < 25; i++) cycle(1'b1, 1'b1);
    check("t5_rise_edge", rise_edge_a, k + SYNC + DA - 1);

    // DEBOUNCE_CYCLES=1 instance follows d_in two edges late.
    for (int i = 0; i < 25; i++) cycle(1'b0, 1'b1);
    rise_edge_b = -1; rise_cnt_b = 0; fall_cnt_b = 0;
    k = n_edge + 1;
    v = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 0) v = ~v;
      cycle(v, 1'b1);
    end
    check("t6_rise_edge", rise_edge_b, k + 2);
    check("t6_rise_count", rise_cnt_b, 4);
    check("t6_fall_count", fall_cnt_b, 4);

    // Randomized levels and strobes.
    for (int n = 0; n < 40; n++) begin
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 30);
      for (int i = 0; i < len; i++) cycle(v, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
